command_tracker: RTL and testbench
==================================

COMMAND_TRACKER -- requirements
Module: command_tracker

Interface
REQ-001 SHALL have parameter: TAGS, 16, number of command tags tracked (1..64); tags 0..TAGS-1 are the only tags used.
REQ-002 SHALL have port: ha_pclock  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: enable  in  1  job running; high permits issue.
REQ-005 SHALL have port: req_valid  in  1  upstream command request.
REQ-006 SHALL have port: req_ready  out  1  request accepted when req_valid && req_ready.
REQ-007 SHALL have ports: req_com in 13, req_ea in 64, req_size in 12  command code, effective address, size.
REQ-008 SHALL have ports: ah_cvalid out 1, ah_ctag out 8, ah_ctagpar out 1, ah_com out 13, ah_compar out 1  PSL command valid, tag, code, with parities.
REQ-009 SHALL have ports: ah_cabt out 3, ah_cea out 64, ah_ceapar out 1, ah_cch out 16, ah_csize out 12  PSL abort mode, address, address parity, context, size.
REQ-010 SHALL have port: ha_croom  in  8  PSL command credits granted at job start.
REQ-011 SHALL have ports: ha_rvalid in 1, ha_rtag in 8, ha_rtagpar in 1, ha_response in 8, ha_rcredits in 9  PSL response interface.
REQ-012 SHALL have ports: done_valid out 1, done_tag out 8, done_response out 8  completion reported upstream.
REQ-013 SHALL have ports: idle out 1 (state IDLE), err out 1 (sticky protocol error).

Function
REQ-014 SHALL implement states IDLE, LOAD, RUN, DRAIN.
- IDLE->LOAD: enable=1.
- LOAD->RUN: always, after one cycle.
- RUN->DRAIN: enable=0.
- DRAIN->IDLE: no tags outstanding.
- DRAIN->RUN: never; enable must drop to IDLE first.
REQ-015 SHALL, in LOAD, load the credit counter (8 bits) with ha_croom and clear the outstanding-tag bitmap (TAGS bits).
REQ-016 SHALL drive req_ready = (state==RUN) && credits!=0 && any tag free, combinationally from registered state only.
REQ-017 SHALL, on accept, assert ah_cvalid for exactly one cycle in the following cycle, carrying:
- ah_ctag = lowest free tag index;
- ah_com, ah_cea, ah_csize = captured request fields.
The accepted tag SHALL be marked outstanding, and credits SHALL decrement by 1.
REQ-018 SHALL generate odd parity: ah_ctagpar = XNOR-reduce(ah_ctag); ah_compar and ah_ceapar likewise over ah_com and ah_cea.
REQ-019 SHALL tie ah_cabt=0 (strict) and ah_cch=0, and hold all command fields at 0 whenever ah_cvalid=0.
REQ-020 SHALL treat a response as valid when ha_rvalid=1, ha_rtag<TAGS, the tag is outstanding, and ha_rtagpar equals odd parity of ha_rtag.
REQ-021 SHALL, on a valid response:
- clear the tag bit;
- add ha_rcredits (9-bit two's complement) to credits, saturating to 0..255;
- next cycle pulse done_valid for one cycle with done_tag=ha_rtag and done_response=ha_response.
REQ-022 SHALL, on an invalid response, set err (held until reset) and leave bitmap, credits and done_valid unchanged.
REQ-023 SHALL, on same-cycle accept and valid response, apply credits = credits - 1 + ha_rcredits (saturated). A tag freed in that cycle SHALL NOT be allocated in that cycle.
REQ-024 SHALL keep accepting responses in DRAIN and RUN, and ignore ha_rvalid in IDLE and LOAD.

Reset
REQ-025 SHALL, while reset_n=0, asynchronously force:
- state=IDLE, credits=0, bitmap=0, err=0;
- ah_cvalid=0, done_valid=0, all command and done fields 0;
- req_ready=0, idle=1.
REQ-026 SHALL drop outstanding tags on reset mid-operation without emitting done pulses; the first post-reset issue requires a new IDLE->LOAD pass.

Verification
REQ-027 SHALL cover: ha_croom=2, enable=1, three back-to-back requests -> tags 0,1 issued on consecutive cycles, third stalls with req_ready=0 until a response with ha_rcredits=1.
REQ-028 SHALL cover: response on tag 1 (ha_response=0x00, correct parity) -> done_valid one cycle later with done_tag=1; tag 1 reused on next issue.
REQ-029 SHALL cover: ha_rtag=5 not outstanding, or wrong ha_rtagpar -> err=1 sticky, no done_valid, credits unchanged.
REQ-030 SHALL cover: same-cycle accept and response with ha_rcredits=1 at credits=1 -> credits stays 1; parity on ah_ctag=0x00 gives ah_ctagpar=1.
REQ-031 SHALL cover: enable drops with 2 tags outstanding -> DRAIN, req_ready=0; idle=1 one cycle after the last response.
REQ-032 SHALL cover: reset_n pulsed low mid-RUN with tags outstanding -> all outputs 0 and idle=1 immediately, with no clock edge required.

Source files
------------

// File: rtl/command_tracker.sv
// PSL command tag tracker: issues upstream requests as PSL commands on the lowest free tag,
// tracks outstanding tags and command credits, and reports completions upstream.
module command_tracker #(
    parameter int TAGS = 16
) (
    input  logic        ha_pclock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [12:0] req_com,
    input  logic [63:0] req_ea,
    input  logic [11:0] req_size,
    output logic        ah_cvalid,
    output logic [7:0]  ah_ctag,
    output logic        ah_ctagpar,
    output logic [12:0] ah_com,
    output logic        ah_compar,
    output logic [2:0]  ah_cabt,
    output logic [63:0] ah_cea,
    output logic        ah_ceapar,
    output logic [15:0] ah_cch,
    output logic [11:0] ah_csize,
    input  logic [7:0]  ha_croom,
    input  logic        ha_rvalid,
    input  logic [7:0]  ha_rtag,
    input  logic        ha_rtagpar,
    input  logic [7:0]  ha_response,
    input  logic [8:0]  ha_rcredits,
    output logic        done_valid,
    output logic [7:0]  done_tag,
    output logic [7:0]  done_response,
    output logic        idle,
    output logic        err
);

    // state    | meaning
    // ST_IDLE  | job not running, responses ignored
    // ST_LOAD  | one cycle: take ha_croom as credits, clear tag bitmap
    // ST_RUN   | issuing commands and accepting responses
    // ST_DRAIN | enable dropped; waiting for outstanding tags to return
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [7:0]        credits_q, credits_d;
    logic [TAGS-1:0]   busy_q, busy_d;
    logic              err_q, err_d;

    logic              cvalid_q;
    logic [7:0]        ctag_q;
    logic              ctagpar_q;
    logic [12:0]       com_q;
    logic              compar_q;
    logic [63:0]       cea_q;
    logic              ceapar_q;
    logic [11:0]       csize_q;

    logic              dvalid_q;
    logic [7:0]        dtag_q;
    logic [7:0]        dresp_q;

    logic              any_free;
    logic [7:0]        free_tag;
    logic [TAGS-1:0]   alloc_mask;
    logic [TAGS-1:0]   rel_mask;
    logic              rsp_hit;
    logic              rsp_active;
    logic              rsp_ok;
    logic              rsp_bad;
    logic              accept;
    logic signed [10:0] rc_ext;
    logic signed [10:0] dec;
    logic signed [10:0] cred_sum;
    logic [7:0]        cred_sat;

    // Descending scan so the last assignment wins with the lowest free index.
    always_comb begin
        any_free = 1'b0;
        free_tag = '0;
        for (int i = TAGS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                any_free = 1'b1;
                free_tag = 8'(i);
            end
        end
    end

    assign req_ready  = (state_q == ST_RUN) && (credits_q != 8'd0) && any_free;
    assign accept     = req_valid && req_ready;
    assign rsp_active = ha_rvalid && ((state_q == ST_RUN) || (state_q == ST_DRAIN));

    always_comb begin
        rsp_hit    = 1'b0;
        alloc_mask = '0;
        rel_mask   = '0;
        for (int i = 0; i < TAGS; i++) begin
            if ((ha_rtag == 8'(i)) && busy_q[i]) begin
                rsp_hit = 1'b1;
            end
            if (accept && (free_tag == 8'(i))) begin
                alloc_mask[i] = 1'b1;
            end
            if (rsp_ok && (ha_rtag == 8'(i))) begin
                rel_mask[i] = 1'b1;
            end
        end
    end

    assign rsp_ok  = rsp_active && rsp_hit && (ha_rtagpar == ~^ha_rtag);
    assign rsp_bad = rsp_active && !rsp_ok;

    // Credit arithmetic is done wide and signed, then clamped to 0..255.
    assign rc_ext   = rsp_ok ? signed'({{2{ha_rcredits[8]}}, ha_rcredits}) : 11'sd0;
    assign dec      = accept ? 11'sd1 : 11'sd0;
    assign cred_sum = signed'({3'b000, credits_q}) + rc_ext - dec;

    always_comb begin
        if (cred_sum < 11'sd0) begin
            cred_sat = 8'd0;
        end else if (cred_sum > 11'sd255) begin
            cred_sat = 8'd255;
        end else begin
            cred_sat = cred_sum[7:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        credits_d = credits_q;
        busy_d    = busy_q;
        err_d     = err_q | rsp_bad;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                credits_d = ha_croom;
                busy_d    = '0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                credits_d = cred_sat;
                busy_d    = (busy_q | alloc_mask) & ~rel_mask;
                if (!enable) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                credits_d = cred_sat;
                busy_d    = (busy_q | alloc_mask) & ~rel_mask;
                if (busy_d == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ha_pclock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            credits_q <= '0;
            busy_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            credits_q <= credits_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    // Command and done registers return to zero whenever no pulse is presented.
    always_ff @(posedge ha_pclock or negedge reset_n) begin
        if (!reset_n) begin
            cvalid_q  <= 1'b0;
            ctag_q    <= '0;
            ctagpar_q <= 1'b0;
            com_q     <= '0;
            compar_q  <= 1'b0;
            cea_q     <= '0;
            ceapar_q  <= 1'b0;
            csize_q   <= '0;
            dvalid_q  <= 1'b0;
            dtag_q    <= '0;
            dresp_q   <= '0;
        end else begin
            cvalid_q  <= accept;
            ctag_q    <= accept ? free_tag : 8'd0;
            ctagpar_q <= accept ? ~^free_tag : 1'b0;
            com_q     <= accept ? req_com : 13'd0;
            compar_q  <= accept ? ~^req_com : 1'b0;
            cea_q     <= accept ? req_ea : 64'd0;
            ceapar_q  <= accept ? ~^req_ea : 1'b0;
            csize_q   <= accept ? req_size : 12'd0;
            dvalid_q  <= rsp_ok;
            dtag_q    <= rsp_ok ? ha_rtag : 8'd0;
            dresp_q   <= rsp_ok ? ha_response : 8'd0;
        end
    end

    assign ah_cvalid     = cvalid_q;
    assign ah_ctag       = ctag_q;
    assign ah_ctagpar    = ctagpar_q;
    assign ah_com        = com_q;
    assign ah_compar     = compar_q;
    assign ah_cabt       = 3'b000;
    assign ah_cea        = cea_q;
    assign ah_ceapar     = ceapar_q;
    assign ah_cch        = 16'h0000;
    assign ah_csize      = csize_q;
    assign done_valid    = dvalid_q;
    assign done_tag      = dtag_q;
    assign done_response = dresp_q;
    assign idle          = (state_q == ST_IDLE);
    assign err           = err_q;

endmodule

// File: tb/tb_command_tracker.sv
// Scoreboard bench for command_tracker: a tag/credit reference model predicts commands and
// completions; a monitor pops and compares them whenever the DUT presents a pulse.
module tb_command_tracker;

    localparam int TAGS    = 16;
    localparam int S_IDLE  = 0;
    localparam int S_LOAD  = 1;
    localparam int S_RUN   = 2;
    localparam int S_DRAIN = 3;

    logic        ha_pclock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [12:0] req_com = '0;
    logic [63:0] req_ea = '0;
    logic [11:0] req_size = '0;
    logic        ah_cvalid;
    logic [7:0]  ah_ctag;
    logic        ah_ctagpar;
    logic [12:0] ah_com;
    logic        ah_compar;
    logic [2:0]  ah_cabt;
    logic [63:0] ah_cea;
    logic        ah_ceapar;
    logic [15:0] ah_cch;
    logic [11:0] ah_csize;
    logic [7:0]  ha_croom = '0;
    logic        ha_rvalid = 1'b0;
    logic [7:0]  ha_rtag = '0;
    logic        ha_rtagpar = 1'b0;
    logic [7:0]  ha_response = '0;
    logic [8:0]  ha_rcredits = '0;
    logic        done_valid;
    logic [7:0]  done_tag;
    logic [7:0]  done_response;
    logic        idle;
    logic        err;

    always #5 ha_pclock = ~ha_pclock;

    command_tracker #(.TAGS(TAGS)) dut (
        .ha_pclock(ha_pclock), .reset_n(reset_n), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_com(req_com), .req_ea(req_ea), .req_size(req_size),
        .ah_cvalid(ah_cvalid), .ah_ctag(ah_ctag), .ah_ctagpar(ah_ctagpar),
        .ah_com(ah_com), .ah_compar(ah_compar), .ah_cabt(ah_cabt),
        .ah_cea(ah_cea), .ah_ceapar(ah_ceapar), .ah_cch(ah_cch), .ah_csize(ah_csize),
        .ha_croom(ha_croom), .ha_rvalid(ha_rvalid), .ha_rtag(ha_rtag),
        .ha_rtagpar(ha_rtagpar), .ha_response(ha_response), .ha_rcredits(ha_rcredits),
        .done_valid(done_valid), .done_tag(done_tag), .done_response(done_response),
        .idle(idle), .err(err)
    );

    typedef struct {
        int          stamp;
        logic [7:0]  tag;
        logic [12:0] com;
        logic [63:0] ea;
        logic [11:0] size;
    } cmd_t;

    typedef struct {
        int         stamp;
        logic [7:0] tag;
        logic [7:0] resp;
    } done_t;

    cmd_t  cmd_q[$];
    done_t done_q[$];
    int    n_tests = 0;
    int    n_fail = 0;
    int    cyc = 0;

    int    m_state;
    int    m_cred;
    bit    m_busy[TAGS];
    bit    m_err;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_cred  = 0;
        m_err   = 1'b0;
        for (int i = 0; i < TAGS; i++) m_busy[i] = 1'b0;
    endtask

    // Called at a falling edge; checks registered outputs, advances one rising edge, returns at the next falling edge.
    task automatic cycle();
        int    n_busy = 0;
        int    first_free = -1;
        int    t;
        int    rc;
        int    nc;
        bit    exp_ready;
        bit    acc;
        bit    rok;
        bit    rbad;
        bit    active;
        bit    any_left;
        cmd_t  c;
        done_t d;
        for (int i = 0; i < TAGS; i++) begin
            if (m_busy[i]) n_busy++;
            else if (first_free < 0) first_free = i;
        end
        exp_ready = (m_state == S_RUN) && (m_cred > 0) && (n_busy < TAGS);
        chk("req_ready", req_ready, exp_ready);
        chk("idle", idle, m_state == S_IDLE);
        chk("err", err, m_err);
        active = (m_state == S_RUN) || (m_state == S_DRAIN);
        acc    = req_valid && exp_ready;
        t      = int'(ha_rtag);
        rok    = 1'b0;
        rbad   = 1'b0;
        if (ha_rvalid && active) begin
            if (t < TAGS && m_busy[t] && (ha_rtagpar == ~^ha_rtag)) rok = 1'b1;
            else rbad = 1'b1;
        end
        rc = int'(ha_rcredits);
        if (ha_rcredits[8]) rc = rc - 512;
        c.tag = 8'(first_free); c.com = req_com; c.ea = req_ea; c.size = req_size;
        d.tag = ha_rtag; d.resp = ha_response;
        @(posedge ha_pclock);
        cyc++;
        if (rbad) m_err = 1'b1;
        if (active) begin
            if (acc) begin
                m_busy[first_free] = 1'b1;
                c.stamp = cyc;
                cmd_q.push_back(c);
            end
            if (rok) begin
                m_busy[t] = 1'b0;
                d.stamp = cyc;
                done_q.push_back(d);
            end
            nc = m_cred - (acc ? 1 : 0) + (rok ? rc : 0);
            if (nc < 0) nc = 0;
            if (nc > 255) nc = 255;
            m_cred = nc;
        end
        any_left = 1'b0;
        for (int i = 0; i < TAGS; i++) if (m_busy[i]) any_left = 1'b1;
        case (m_state)
            S_IDLE:  if (enable) m_state = S_LOAD;
            S_LOAD: begin
                m_cred = int'(ha_croom);
                for (int i = 0; i < TAGS; i++) m_busy[i] = 1'b0;
                m_state = S_RUN;
            end
            S_RUN:   if (!enable) m_state = S_DRAIN;
            default: if (!any_left) m_state = S_IDLE;
        endcase
        @(negedge ha_pclock);
    endtask

    task automatic do_reset();
        chk("no pending cmd before reset", cmd_q.size(), 0);
        chk("no pending done before reset", done_q.size(), 0);
        reset_n = 1'b0;
        #1;
        chk("rst ah_cvalid", ah_cvalid, 0);
        chk("rst done_valid", done_valid, 0);
        chk("rst req_ready", req_ready, 0);
        chk("rst idle", idle, 1);
        chk("rst err", err, 0);
        chk("rst cmd fields", |{ah_ctag, ah_ctagpar, ah_com, ah_compar, ah_cabt, ah_cea, ah_ceapar, ah_cch, ah_csize}, 0);
        chk("rst done fields", |{done_tag, done_response}, 0);
        model_reset();
        enable    = 1'b0;
        req_valid = 1'b0;
        ha_rvalid = 1'b0;
        @(posedge ha_pclock);
        @(negedge ha_pclock);
        reset_n = 1'b1;
    endtask

    task automatic set_req(bit v);
        req_valid = v;
        req_com   = 13'($urandom);
        req_ea    = {$urandom, $urandom};
        req_size  = 12'($urandom);
    endtask

    task automatic set_rsp(bit v, int tag, int cr, logic [7:0] resp, bit badpar);
        logic [7:0] tg;
        tg          = tag[7:0];
        ha_rvalid   = v;
        ha_rtag     = tg;
        ha_rtagpar  = (~^tg) ^ badpar;
        ha_rcredits = cr[8:0];
        ha_response = resp;
    endtask

    always @(posedge ha_pclock) begin : monitor
        cmd_t  ce;
        done_t de;
        #1;
        if (reset_n) begin
            if (ah_cvalid) begin
                if (cmd_q.size() == 0) begin
                    chk("unexpected ah_cvalid", 1, 0);
                end else begin
                    ce = cmd_q.pop_front();
                    chk("cmd timing", cyc, ce.stamp);
                    chk("ah_ctag", ah_ctag, ce.tag);
                    chk("ah_ctagpar", ah_ctagpar, ~^ce.tag);
                    chk("ah_com", ah_com, ce.com);
                    chk("ah_compar", ah_compar, ~^ce.com);
                    chk("ah_cea", ah_cea, ce.ea);
                    chk("ah_ceapar", ah_ceapar, ~^ce.ea);
                    chk("ah_csize", ah_csize, ce.size);
                    chk("ah_cabt/cch", {ah_cabt, ah_cch}, 0);
                end
            end else begin
                chk("cmd fields idle", |{ah_ctag, ah_ctagpar, ah_com, ah_compar, ah_cabt, ah_cea, ah_ceapar, ah_cch, ah_csize}, 0);
            end
            if (done_valid) begin
                if (done_q.size() == 0) begin
                    chk("unexpected done_valid", 1, 0);
                end else begin
                    de = done_q.pop_front();
                    chk("done timing", cyc, de.stamp);
                    chk("done_tag", done_tag, de.tag);
                    chk("done_response", done_response, de.resp);
                end
            end else begin
                chk("done fields idle", |{done_tag, done_response}, 0);
            end
        end
    end

    initial begin
        int outstanding[$];
        model_reset();
        do_reset();

        // Two credits, three back-to-back requests: third stalls until a credit returns.
        ha_croom = 8'd2;
        enable   = 1'b1;
        cycle();
        cycle();
        for (int k = 0; k < 4; k++) begin
            set_req(1);
            cycle();
        end
        set_rsp(1, 0, 1, 8'h5A, 0);
        cycle();
        set_rsp(0, 0, 0, 8'h00, 0);
        cycle();
        set_req(0);

        // Completion on tag 1, then tag 1 is reused.
        set_rsp(1, 1, 1, 8'h00, 0);
        cycle();
        set_rsp(0, 0, 0, 8'h00, 0);
        cycle();
        set_req(1);
        cycle();
        set_req(0);
        cycle();

        // Response on a tag not outstanding, then one with bad parity; credits must not move.
        set_rsp(1, 5, 1, 8'h11, 0);
        cycle();
        set_rsp(1, 0, 3, 8'h22, 1);
        cycle();
        set_rsp(0, 0, 0, 8'h00, 0);
        cycle();
        cycle();

        // Same-cycle accept and response at one credit.
        set_rsp(1, 0, 1, 8'h33, 0);
        cycle();
        set_req(1);
        set_rsp(1, 1, 1, 8'h44, 0);
        cycle();
        set_rsp(0, 0, 0, 8'h00, 0);
        cycle();
        set_req(0);
        cycle();

        // Drain with two tags outstanding.
        enable = 1'b0;
        cycle();
        set_req(1);
        cycle();
        set_rsp(1, 0, 0, 8'h55, 0);
        cycle();
        set_rsp(1, 1, 0, 8'h66, 0);
        cycle();
        set_rsp(0, 0, 0, 8'h00, 0);
        set_req(0);
        cycle();
        cycle();

        // Asynchronous reset mid-run while a command pulse is on the bus.
        ha_croom = 8'd4;
        enable   = 1'b1;
        cycle();
        cycle();
        set_req(1);
        cycle();
        cycle();
        set_req(0);
        do_reset();
        enable = 1'b1;
        set_req(1);
        for (int k = 0; k < 4; k++) cycle();
        set_req(0);
        do_reset();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 99) < 2) enable = ~enable;
            if (m_state == S_IDLE && $urandom_range(0, 3) == 0) enable = 1'b1;
            ha_croom = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(1, 6));
            set_req(bit'($urandom_range(0, 1)));
            outstanding.delete();
            for (int i = 0; i < TAGS; i++) if (m_busy[i]) outstanding.push_back(i);
            if ($urandom_range(0, 99) < 40) begin
                int tg;
                int cr;
                if (outstanding.size() > 0 && $urandom_range(0, 99) < 95)
                    tg = outstanding[$urandom_range(0, outstanding.size() - 1)];
                else
                    tg = $urandom_range(0, TAGS + 3);
                cr = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 2);
                set_rsp(1, tg, cr, 8'($urandom), bit'($urandom_range(0, 99) < 3));
            end else begin
                set_rsp(0, 0, 0, 8'h00, 0);
            end
            if ($urandom_range(0, 999) < 3) begin
                ha_rvalid = 1'b0;
                req_valid = 1'b0;
                cycle();
                do_reset();
            end else begin
                cycle();
            end
        end
        set_req(0);
        set_rsp(0, 0, 0, 8'h00, 0);
        cycle();
        cycle();
        chk("cmd queue empty at end", cmd_q.size(), 0);
        chk("done queue empty at end", done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
